tow_pull_arbiter: RTL

- Arbitrates and sequences the two players' synchronized button inputs in the tug-of-war game.
- Detects rising edges on each player's button and grants at most one "pull" per cycle, with fair handling of simultaneous presses.
- Enforces a lockout window after every accepted pull and tracks rope position until one side wins.
- Sits between the per-button two-flop synchronizers and the display/score logic.

---
 rtl/tow_pull_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/tow_pull_arbiter.sv
// Tug-of-war pull arbiter: edge-detects both buttons, grants at most one pull per cycle,
// applies a post-pull lockout and tracks rope position. Optional macro: TOW_TIE_CANCEL_EN.
module tow_pull_arbiter #(
    parameter int unsigned LIMIT       = 8,
    parameter int unsigned LOCKOUT_CYC = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              l_in,
    input  logic              r_in,
    output logic              grant_l,
    output logic              grant_r,
    output logic signed [7:0] pos,
    output logic [1:0]        winner,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, PLAY, LOCK, DONE} state_t;

    localparam logic signed [7:0] POS_LIM   = 8'(LIMIT);
    localparam logic [7:0]        LOCK_LOAD = 8'(LOCKOUT_CYC - 1);

    state_t            state, state_next;
    logic              l_q, r_q;
    logic              l_rise, r_rise;
    logic              prio, prio_next;
    logic [7:0]        lock_cnt, cnt_next;
    logic signed [7:0] pos_next, pos_step;
    logic              take_l, take_r, restart;
    logic              grant_l_d, grant_r_d, busy_d;
    logic [1:0]        winner_d;

    assign l_rise = l_in & ~l_q;
    assign r_rise = r_in & ~r_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            l_q      <= 1'b0;
            r_q      <= 1'b0;
            prio     <= 1'b0;
            lock_cnt <= '0;
            pos      <= '0;
            winner   <= '0;
            grant_l  <= 1'b0;
            grant_r  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            l_q      <= l_in;
            r_q      <= r_in;
            prio     <= prio_next;
            lock_cnt <= cnt_next;
            pos      <= pos_next;
            winner   <= winner_d;
            grant_l  <= grant_l_d;
            grant_r  <= grant_r_d;
            busy     <= busy_d;
        end
    end

    // prio: 0 = left wins the next tie, 1 = right wins it
    always_comb begin
        state_next = state;
        prio_next  = prio;
        cnt_next   = lock_cnt;
        pos_next   = pos;
        pos_step   = pos;
        take_l     = 1'b0;
        take_r     = 1'b0;
        restart    = 1'b0;
        if (start) begin
            restart    = 1'b1;
            state_next = PLAY;
            prio_next  = 1'b0;
            cnt_next   = '0;
            pos_next   = '0;
        end else begin
            case (state)
                PLAY: begin
`ifdef TOW_TIE_CANCEL_EN
                    if (l_rise ^ r_rise) begin
                        take_l = l_rise;
                        take_r = r_rise;
                    end
`else
                    if (l_rise && r_rise) begin
                        take_l    = ~prio;
                        take_r    = prio;
                        prio_next = ~prio;
                    end else begin
                        take_l = l_rise;
                        take_r = r_rise;
                    end
`endif
                    if (take_l || take_r) begin
                        pos_step = take_l ? pos - 8'sd1 : pos + 8'sd1;
                        pos_next = pos_step;
                        if (pos_step == POS_LIM || pos_step == -POS_LIM) begin
                            state_next = DONE;
                        end else begin
                            state_next = LOCK;
                            cnt_next   = LOCK_LOAD;
                        end
                    end
                end
                LOCK: begin
                    if (lock_cnt == '0) state_next = PLAY;
                    else                cnt_next   = lock_cnt - 8'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        grant_l_d = take_l;
        grant_r_d = take_r;
        busy_d    = (state_next == PLAY) || (state_next == LOCK);
        winner_d  = winner;
        if (restart)
            winner_d = 2'b00;
        else if (state == PLAY && state_next == DONE)
            winner_d = take_l ? 2'b01 : 2'b10;
    end

endmodule
